// File: rtl/dmem_uart_if.sv
// Core load/store bus seen by the data-memory block: word address, store
// data and strobe from the core, combinational load data back to it.
interface dmem_uart_if;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        write_en;
  logic [15:0] rdata;

  modport master (output addr, output wdata, output write_en, input rdata);
  modport slave  (input addr, input wdata, input write_en, output rdata);
endinterface

// File: rtl/dmem_uart.sv
// Data-side memory: word-addressed RAM with asynchronous read, plus a
// memory-mapped 8N1 UART transmitter (0xFFF0 data, 0xFFF1 status) fed by
// a small TX FIFO. The UART is only built when DMEM_UART_EN is defined;
// otherwise uart_tx idles high and the UART addresses read as unmapped.
module dmem_uart #(
  parameter int RAM_DEPTH    = 1024,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  dmem_uart_if.slave bus,
  output logic       uart_tx
);
  localparam int          AW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [16:0] RAM_LIMIT = 17'(RAM_DEPTH);

  // RAM is read combinationally so a load completes in the same cycle
  logic [15:0]   mem [RAM_DEPTH];
  logic          in_ram;
  logic [AW-1:0] ram_idx;
  logic [15:0]   rdata_int;

  assign in_ram  = {1'b0, bus.addr} < RAM_LIMIT;
  assign ram_idx = bus.addr[AW-1:0];

  // RAM store; contents deliberately not reset
  always_ff @(posedge clk) begin
    if (bus.write_en && in_ram) mem[ram_idx] <= bus.wdata;
  end

`ifdef DMEM_UART_EN
  localparam logic [15:0] UART_DATA = 16'hFFF0;
  localparam logic [15:0] UART_STAT = 16'hFFF1;
  localparam int          PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW        = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam int          BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic full, empty, busy, baud_done;
  logic push_req, push_ok, stat_wr, pop;

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign busy      = (state != IDLE);
  assign baud_done = (baud == BAUD_LAST);
  assign push_req  = bus.write_en && (bus.addr == UART_DATA);
  assign stat_wr   = bus.write_en && (bus.addr == UART_STAT);
  // The FSM takes a byte when idle, or at the very last stop-bit cycle so
  // that back-to-back frames have no gap.
  assign pop       = !empty && ((state == IDLE) || ((state == STOP) && baud_done));
  // A pop on the same edge frees a slot, so a push into a full FIFO survives
  assign push_ok   = push_req && (!full || pop);

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push_ok) fifo[wr_ptr] <= bus.wdata[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (stat_wr)                   overflow <= 1'b0;
      else if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  // TX frame sequencer with registered line output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      uart_tx <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (pop) begin
            shift   <= fifo[rd_ptr];
            baud    <= '0;
            state   <= START;
            uart_tx <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= DATA;
            uart_tx <= shift[0];
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shift[bit_idx + 3'd1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud_done) begin
            baud <= '0;
            if (pop) begin
              shift   <= fifo[rd_ptr];
              state   <= START;
              uart_tx <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end
`else
  // Without the UART the line simply rests at the idle level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) uart_tx <= 1'b1;
    else      uart_tx <= 1'b1;
  end
`endif

  // Load data mux: RAM, status register, or zero for everything else
  always_comb begin
    rdata_int = 16'h0000;
    if (in_ram) begin
      rdata_int = mem[ram_idx];
    end
`ifdef DMEM_UART_EN
    else if (bus.addr == UART_STAT) begin
      rdata_int = {12'b0, busy, overflow, empty, full};
    end
`endif
  end

  assign bus.rdata = rdata_int;
endmodule

// File: tb/tb_dmem_uart.sv
// Self-checking bench for dmem_uart. The reference model tracks RAM contents
// in an array, the TX FIFO as a byte queue, and the line as a frame timeline
// (cycles remaining in the current 10-bit frame); the expected line level is
// computed from the position inside that frame.
module tb_dmem_uart;
  localparam int CPB   = 4;
  localparam int FD    = 4;
  localparam int RD    = 1024;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic uart_tx;

  dmem_uart_if bus ();

  dmem_uart #(.RAM_DEPTH(RD), .FIFO_DEPTH(FD), .CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  logic [15:0]  ram_m  [RD];
  bit           ram_ok [RD];
  byte unsigned q[$];
  bit           m_ovf;
  int           m_remain;
  logic [7:0]   m_cur;

  function automatic void m_reset();
    q.delete();
    m_ovf    = 1'b0;
    m_remain = 0;
    m_cur    = 8'h00;
  endfunction

  function automatic logic m_tx();
    int pos;
    if (!rst || m_remain == 0) return 1'b1;
    pos = (FRAME - m_remain) / CPB;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return m_cur[pos-1];
  endfunction

  function automatic logic [15:0] m_rdata(input logic [15:0] a);
    if (a < RD) return ram_m[a];
`ifdef DMEM_UART_EN
    if (a == 16'hFFF1)
      return {12'b0, (m_remain > 0), m_ovf, (q.size() == 0), (q.size() == FD)};
`endif
    return 16'h0000;
  endfunction

  // One clock edge's worth of behaviour
  function automatic void m_step(input logic [15:0] a, input bit w, input logic [15:0] d);
    bit pop;
    if (!rst) begin
      m_reset();
      return;
    end
    if (w && a < RD) begin
      ram_m[a]  = d;
      ram_ok[a] = 1'b1;
    end
`ifdef DMEM_UART_EN
    pop = (q.size() > 0) && (m_remain <= 1);
    if (pop) begin
      m_cur    = q.pop_front();
      m_remain = FRAME;
    end else if (m_remain > 0) begin
      m_remain--;
    end
    if (w && a == 16'hFFF0) begin
      if (q.size() < FD) q.push_back(d[7:0]);
      else               m_ovf = 1'b1;
    end
    if (w && a == 16'hFFF1) m_ovf = 1'b0;
`else
    pop = 1'b0;
    if (pop) m_remain = 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one bus cycle: check load data and line before the edge, then step
  task automatic cycle(input logic [15:0] a, input bit w, input logic [15:0] d);
    bus.addr     = a;
    bus.write_en = w;
    bus.wdata    = d;
    @(negedge clk);
    if (!(a < RD && !ram_ok[a])) chk("rdata", bus.rdata, m_rdata(a));
    chk("uart_tx", {15'b0, uart_tx}, {15'b0, m_tx()});
    @(posedge clk);
    m_step(a, w, d);
    #1;
  endtask

  task automatic peek(input string tag, input logic [15:0] a, input logic [15:0] exp);
    bus.addr     = a;
    bus.write_en = 1'b0;
    #1;
    chk(tag, bus.rdata, exp);
  endtask

  task automatic wait_remain(input int target);
    int n = 0;
    while (m_remain != target && n < 200) begin
      cycle(16'hFFF1, 1'b0, 16'h0000);
      n++;
    end
    if (m_remain != target) begin
      vectors++;
      miscompares++;
      $error("FAIL wait_frame_pos: observed remain %0d expected %0d", m_remain, target);
    end
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] d;
    int r;

    for (int i = 0; i < RD; i++) begin
      ram_m[i]  = 16'h0000;
      ram_ok[i] = 1'b0;
    end
    m_reset();
    bus.addr = 16'hFFF1; bus.wdata = 16'h0000; bus.write_en = 1'b0;

    // reset state: status visible during and after reset
    #1;
    repeat (3) cycle(16'hFFF1, 1'b0, 16'h0000);
`ifdef DMEM_UART_EN
    peek("stat_in_reset", 16'hFFF1, 16'h0002);
`else
    peek("stat_in_reset", 16'hFFF1, 16'h0000);
`endif
    chk("tx_in_reset", {15'b0, uart_tx}, 16'h0001);
    rst = 1'b1;
    repeat (2) cycle(16'hFFF1, 1'b0, 16'h0000);

    // RAM access, out-of-range and same-cycle read-before-write
    cycle(16'h0005, 1'b1, 16'hBEEF);
    cycle(16'h0005, 1'b0, 16'h0000);
    peek("ram_5", 16'h0005, 16'hBEEF);
    cycle(16'h0400, 1'b0, 16'h0000);
    cycle(16'h0400, 1'b1, 16'h1234);
    cycle(16'h0400, 1'b0, 16'h0000);
    peek("ram_400", 16'h0400, 16'h0000);
    cycle(16'h0005, 1'b1, 16'h1111);
    peek("ram_5_new", 16'h0005, 16'h1111);
    cycle(16'h03FF, 1'b1, 16'hA5A5);
    peek("ram_top", 16'h03FF, 16'hA5A5);
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) cycle(a, 1'b1, 16'($urandom));
      else                           cycle(a, 1'b0, 16'h0000);
    end

`ifdef DMEM_UART_EN
    // single byte 0xA5 (upper bits ignored), then idle status
    cycle(16'hFFF0, 1'b1, 16'h01A5);
    repeat (FRAME + 4) cycle(16'hFFF1, 1'b0, 16'h0000);
    peek("stat_after_byte", 16'hFFF1, 16'h0002);

    // burst of six: five accepted, sixth overflows
    for (int i = 0; i < 6; i++) cycle(16'hFFF0, 1'b1, 16'($urandom_range(0, 255)));
    peek("stat_overflow", 16'hFFF1, 16'h000D);
    repeat (5 * FRAME + 4) cycle(16'hFFF1, 1'b0, 16'h0000);
    peek("stat_ovf_idle", 16'hFFF1, 16'h0006);
    cycle(16'hFFF1, 1'b1, 16'h0000);
    peek("stat_ovf_clear", 16'hFFF1, 16'h0002);

    // full FIFO with a push on the exact cycle the stop bit ends
    for (int i = 0; i < 5; i++) cycle(16'hFFF0, 1'b1, 16'($urandom_range(0, 255)));
    peek("stat_full", 16'hFFF1, 16'h0009);
    wait_remain(1);
    cycle(16'hFFF0, 1'b1, 16'h005A);
    peek("stat_full_pop", 16'hFFF1, 16'h0009);
    repeat (5 * FRAME + 4) cycle(16'hFFF1, 1'b0, 16'h0000);
    peek("stat_drained", 16'hFFF1, 16'h0002);

    // reset in the middle of data bit 3 (bit 3 forced low)
    d = 16'($urandom_range(0, 255)) & 16'h00F7;
    cycle(16'hFFF0, 1'b1, d);
    cycle(16'hFFF0, 1'b1, 16'h00FF);
    wait_remain(FRAME - 4 * CPB - 2);
    chk("tx_bit3", {15'b0, uart_tx}, 16'h0000);
    rst = 1'b0;
    m_reset();
    #1;
    chk("tx_async_reset", {15'b0, uart_tx}, 16'h0001);
    peek("stat_mid_reset", 16'hFFF1, 16'h0002);
    repeat (2) cycle(16'hFFF1, 1'b0, 16'h0000);
    rst = 1'b1;
    repeat (FRAME + 10) cycle(16'hFFF1, 1'b0, 16'h0000);
    peek("stat_after_reset", 16'hFFF1, 16'h0002);
`else
    // UART addresses behave as unmapped and the line never moves
    cycle(16'hFFF0, 1'b1, 16'h01A5);
    peek("stat_disabled", 16'hFFF1, 16'h0000);
    cycle(16'hFFF1, 1'b1, 16'hFFFF);
    peek("data_disabled", 16'hFFF0, 16'h0000);
    repeat (FRAME) cycle(16'hFFF1, 1'b0, 16'h0000);
    chk("tx_disabled", {15'b0, uart_tx}, 16'h0001);
`endif

    // randomized mix of every address region
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 11);
      case (r)
        0, 1, 2: cycle(16'($urandom_range(0, 63)), 1'b1, 16'($urandom));
        3, 4:    cycle(16'($urandom_range(0, 63)), 1'b0, 16'h0000);
        5:       cycle(16'hFFF0, 1'b1, 16'($urandom));
        6, 7:    cycle(16'hFFF1, 1'b0, 16'h0000);
        8:       cycle(16'hFFF1, 1'b1, 16'($urandom));
        9:       cycle(16'($urandom_range(RD, 16'hFFEF)), 1'($urandom_range(0, 1)), 16'($urandom));
        10:      cycle(16'($urandom_range(16'hFFF2, 16'hFFFF)), 1'($urandom_range(0, 1)), 16'($urandom));
        default: cycle(16'hFFF0, 1'b0, 16'h0000);
      endcase
    end
    repeat (FD * FRAME + FRAME + 4) cycle(16'hFFF1, 1'b0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
